// File: rtl/twiddle_rom_gen.sv
// twiddle_rom_gen: carrier number -> {cos, sin} twiddle factor for the OFDM FFT.
// Three-stage stall-capable pipeline. S1 reads the index table. S2 reads the
// quarter-wave cosine table twice. S3 applies quadrant symmetry and optional
// conjugation. Inputs come from the external port or from a self-running sweep.
module twiddle_rom_gen #(
    parameter int N_PT    = 384,
    parameter int A_WIDTH = 9,
    parameter int PH_BITS = 4,
    parameter int TW_W    = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [A_WIDTH-1:0]  din_num,
    input  logic                din_vld,
    input  logic                din_inv,
    output logic                din_rdy,
    input  logic                start,
    input  logic                start_inv,
    output logic                busy,
    output logic [2*TW_W-1:0]   dout,
    output logic                dout_vld,
    input  logic                dout_rdy,
    output logic                dout_last
);

    localparam int Q = 2 ** (PH_BITS - 2);
    localparam logic [PH_BITS-1:0] R_MASK   = PH_BITS'(Q - 1);
    localparam logic [PH_BITS-1:0] Q_IDX    = PH_BITS'(Q);
    localparam logic [A_WIDTH-1:0] LAST_CNT = A_WIDTH'(N_PT - 1);

    // Quarter-wave cosine entry floor(cos(2*pi*i/2**PH_BITS) * 2**(TW_W-2)).
    // The value comes from a fixed-point Taylor series in Q28. The endpoints
    // are exact so that 1.0 and 0.0 come out clean.
    function automatic int qcosEntry(input int i);
        longint piQ;
        longint x;
        longint term;
        longint sum;
        if (i == 0) return 1 << (TW_W - 2);
        if (i >= Q) return 0;
        piQ  = 64'sd843314857;
        x    = (2 * piQ * longint'(i)) >>> PH_BITS;
        term = 64'sd1 <<< 28;
        sum  = term;
        for (int n = 1; n <= 10; n++) begin
            term = -((((term * x) >>> 28) * x) >>> 28) / longint'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        if (sum < 0) sum = 0;
        return int'(sum >>> (28 - (TW_W - 2)));
    endfunction

    // Index table: carrier n maps to phase n mod 2**PH_BITS. Carriers beyond
    // N_PT map to phase 0, which gives (1.0, 0).
    logic [PH_BITS-1:0] idxRom [2**A_WIDTH];
    logic [TW_W-1:0]    qcosRom [2**PH_BITS];

    for (genvar a = 0; a < 2 ** A_WIDTH; a++) begin : g_idx
        assign idxRom[a] = (a < N_PT) ? PH_BITS'(a % (2 ** PH_BITS)) : '0;
    end

    for (genvar i = 0; i < 2 ** PH_BITS; i++) begin : g_qcos
        localparam int CV = qcosEntry(i);
        assign qcosRom[i] = TW_W'(CV);
    end

    // Control registers
    logic               busy_q, busy_d;
    logic               issuing_q, issuing_d;
    logic [A_WIDTH-1:0] cnt_q, cnt_d;
    logic               sweepInv_q, sweepInv_d;

    // Pipeline registers
    logic               s1Vld_q, s1Inv_q, s1Last_q;
    logic [PH_BITS-1:0] s1Idx_q;
    logic               s1Vld_d, s1Inv_d, s1Last_d;
    logic [PH_BITS-1:0] s1Idx_d;

    logic               s2Vld_q, s2Inv_q, s2Last_q;
    logic [1:0]         s2Quad_q;
    logic [TW_W-1:0]    s2CosR_q, s2CosQr_q;
    logic [PH_BITS-1:0] rIdx, rCompl;

    logic               doutVld_q, doutLast_q;
    logic [2*TW_W-1:0]  dout_q, dout_d;
    logic [TW_W-1:0]    reMap, imMap, imOut;

    logic pipeEn, startFire, extFire, autoFire, lastAccept;

    assign pipeEn     = !doutVld_q || dout_rdy;
    assign startFire  = start && !busy_q;
    assign din_rdy    = pipeEn && !busy_q && !start;
    assign extFire    = din_vld && din_rdy;
    assign autoFire   = busy_q && issuing_q && pipeEn;
    assign lastAccept = doutVld_q && dout_rdy && doutLast_q;

    // Sweep sequencing: start arms the counter, each unstalled cycle issues one carrier
    always_comb begin
        busy_d     = busy_q;
        issuing_d  = issuing_q;
        cnt_d      = cnt_q;
        sweepInv_d = sweepInv_q;
        if (startFire) begin
            busy_d     = 1'b1;
            issuing_d  = 1'b1;
            cnt_d      = '0;
            sweepInv_d = start_inv;
        end else begin
            if (autoFire) begin
                if (cnt_q == LAST_CNT) begin
                    issuing_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (lastAccept) begin
                busy_d = 1'b0;
            end
        end
    end

    // S1 next state: select the address source and look up the phase index
    always_comb begin
        s1Vld_d  = extFire || autoFire;
        s1Inv_d  = busy_q ? sweepInv_q : din_inv;
        s1Last_d = autoFire && (cnt_q == LAST_CNT);
        s1Idx_d  = idxRom[busy_q ? cnt_q : din_num];
    end

    assign rIdx   = s1Idx_q & R_MASK;
    assign rCompl = Q_IDX - rIdx;

    // S3 next state: quadrant symmetry, then conjugation for the IFFT
    always_comb begin
        reMap = s2CosR_q;
        imMap = s2CosQr_q;
        case (s2Quad_q)
            2'd0: begin
                reMap = s2CosR_q;
                imMap = s2CosQr_q;
            end
            2'd1: begin
                reMap = -s2CosQr_q;
                imMap = s2CosR_q;
            end
            2'd2: begin
                reMap = -s2CosR_q;
                imMap = -s2CosQr_q;
            end
            default: begin
                reMap = s2CosQr_q;
                imMap = -s2CosR_q;
            end
        endcase
        imOut  = s2Inv_q ? -imMap : imMap;
        dout_d = {reMap, imOut};
    end

    // Control state update; reset aborts any sweep immediately
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy_q     <= 1'b0;
            issuing_q  <= 1'b0;
            cnt_q      <= '0;
            sweepInv_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            issuing_q  <= issuing_d;
            cnt_q      <= cnt_d;
            sweepInv_q <= sweepInv_d;
        end
    end

    // Pipeline advance: every stage moves together and all hold on a downstream stall
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1Vld_q    <= 1'b0;
            s1Inv_q    <= 1'b0;
            s1Last_q   <= 1'b0;
            s1Idx_q    <= '0;
            s2Vld_q    <= 1'b0;
            s2Inv_q    <= 1'b0;
            s2Last_q   <= 1'b0;
            s2Quad_q   <= '0;
            s2CosR_q   <= '0;
            s2CosQr_q  <= '0;
            doutVld_q  <= 1'b0;
            doutLast_q <= 1'b0;
            dout_q     <= '0;
        end else if (pipeEn) begin
            s1Vld_q    <= s1Vld_d;
            s1Inv_q    <= s1Inv_d;
            s1Last_q   <= s1Last_d;
            s1Idx_q    <= s1Idx_d;
            s2Vld_q    <= s1Vld_q;
            s2Inv_q    <= s1Inv_q;
            s2Last_q   <= s1Last_q;
            s2Quad_q   <= s1Idx_q[PH_BITS-1 -: 2];
            s2CosR_q   <= qcosRom[rIdx];
            s2CosQr_q  <= qcosRom[rCompl];
            doutVld_q  <= s2Vld_q;
            doutLast_q <= s2Last_q;
            dout_q     <= dout_d;
        end
    end

    assign busy      = busy_q;
    assign dout      = dout_q;
    assign dout_vld  = doutVld_q;
    assign dout_last = doutLast_q;

endmodule
